// File: rtl/inside_multi.sv
`default_nettype none
// ============================================================================
//  Module   : inside_multi
//  Purpose  : Tests whether device point D=(xD,yD) lies within radius rA_k of
//             each of K anchors. The anchors share one subtract/square/compare
//             datapath and take three cycles each. The block returns a
//             per-anchor mask, a popcount and an all-inside flag over a
//             valid/ready handshake.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             in_valid/in_ready - request handshake (ready only when idle)
//             xD, yD           - device point, unsigned N bits
//             xA_bus, yA_bus   - anchor coordinates, signed N bits per anchor
//             rA_bus           - anchor radii, unsigned N+1 bits per anchor
//             out_valid/out_ready - result handshake
//             mask, count, all_in - result, held while out_valid=1
//  Revision : 1.0 - initial release
// ============================================================================
module inside_multi #(
  parameter int N         = 8,
  parameter int K         = 3,
  parameter int INCLUSIVE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         xD,
  input  logic [N-1:0]         yD,
  input  logic [K*N-1:0]       xA_bus,
  input  logic [K*N-1:0]       yA_bus,
  input  logic [K*(N+1)-1:0]   rA_bus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K-1:0]         mask,
  output logic [$clog2(K+1)-1:0] count,
  output logic                 all_in
);

  localparam int CW = $clog2(K+1);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int SW = 2*N+2;   // width of one square

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIFF = 3'd1,
    S_SQR  = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [N-1:0]          r_xd, r_yd;
  logic [K*N-1:0]        r_xa_bus, r_ya_bus;
  logic [K*(N+1)-1:0]    r_ra_bus;
  logic signed [N+1:0]   r_dx, r_dy;
  logic [SW-1:0]         r_dx2, r_dy2, r_r2;
  logic [K-1:0]          r_mask;
  logic [CW-1:0]         r_count;
  logic                  r_all_in;
  logic                  r_in_ready;
  logic                  r_out_valid;

  // Current anchor selected from the captured buses
  logic [N-1:0]          w_xa, w_ya;
  logic [N:0]            w_r;
  logic signed [N+1:0]   w_dx, w_dy;
  logic [N+1:0]          w_adx, w_ady;
  logic [SW-1:0]         w_dx2, w_dy2, w_r2;
  logic [SW:0]           w_sum, w_r2x;
  logic                  w_inside;
  logic [K-1:0]          w_mask_next;
  logic                  w_last;

  assign w_xa = r_xa_bus[r_idx*N +: N];
  assign w_ya = r_ya_bus[r_idx*N +: N];
  assign w_r  = r_ra_bus[r_idx*(N+1) +: N+1];

  // Zero-extend the unsigned device coordinate, sign-extend the anchor;
  // N+2 bits holds every difference without wrap.
  assign w_dx = $signed({2'b00, r_xd}) - $signed({{2{w_xa[N-1]}}, w_xa});
  assign w_dy = $signed({2'b00, r_yd}) - $signed({{2{w_ya[N-1]}}, w_ya});

  // Square the magnitude as an unsigned value; |d| < 2^(N+1) so the product
  // fits exactly in 2N+2 bits.
  assign w_adx = r_dx[N+1] ? $unsigned(-r_dx) : $unsigned(r_dx);
  assign w_ady = r_dy[N+1] ? $unsigned(-r_dy) : $unsigned(r_dy);
  assign w_dx2 = {{N{1'b0}}, w_adx} * {{N{1'b0}}, w_adx};
  assign w_dy2 = {{N{1'b0}}, w_ady} * {{N{1'b0}}, w_ady};
  assign w_r2  = {{(N+1){1'b0}}, w_r} * {{(N+1){1'b0}}, w_r};

  // One extra bit on the sum so two maximal squares never overflow
  assign w_sum    = {1'b0, r_dx2} + {1'b0, r_dy2};
  assign w_r2x    = {1'b0, r_r2};
  assign w_inside = (INCLUSIVE != 0) ? (w_sum <= w_r2x) : (w_sum < w_r2x);
  assign w_last   = (r_idx == IW'(K-1));

  always_comb begin
    w_mask_next = r_mask;
    for (int k = 0; k < K; k++) begin
      if (r_idx == IW'(k)) begin
        w_mask_next[k] = w_inside;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_xd        <= '0;
      r_yd        <= '0;
      r_xa_bus    <= '0;
      r_ya_bus    <= '0;
      r_ra_bus    <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_dx2       <= '0;
      r_dy2       <= '0;
      r_r2        <= '0;
      r_mask      <= '0;
      r_count     <= '0;
      r_all_in    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_xd       <= xD;
            r_yd       <= yD;
            r_xa_bus   <= xA_bus;
            r_ya_bus   <= yA_bus;
            r_ra_bus   <= rA_bus;
            r_mask     <= '0;
            r_count    <= '0;
            r_all_in   <= 1'b0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_DIFF;
          end
        end
        S_DIFF: begin
          r_dx    <= w_dx;
          r_dy    <= w_dy;
          r_state <= S_SQR;
        end
        S_SQR: begin
          r_dx2   <= w_dx2;
          r_dy2   <= w_dy2;
          r_r2    <= w_r2;
          r_state <= S_CMP;
        end
        S_CMP: begin
          r_mask <= w_mask_next;
          if (w_inside) begin
            r_count <= r_count + CW'(1);
          end
          if (w_last) begin
            r_all_in    <= &w_mask_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_state <= S_DIFF;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign mask      = r_mask;
  assign count     = r_count;
  assign all_in    = r_all_in;

endmodule
`default_nettype wire

// File: tb/tb_inside_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inside_multi
//  Purpose  : Self-checking bench for inside_multi. A K=3 inclusive instance
//             and a K=1 exclusive instance are driven with directed and
//             random requests and compared against an integer distance model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inside_multi;

  localparam int N = 8;
  localparam int K = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Main instance: K=3, inclusive compare
  logic               in_valid, in_ready, out_valid, out_ready, all_in;
  logic [N-1:0]       xd, yd;
  logic [K*N-1:0]     xa_bus, ya_bus;
  logic [K*(N+1)-1:0] ra_bus;
  logic [K-1:0]       mask;
  logic [1:0]         count;

  // Second instance: K=1, exclusive compare
  logic               e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_all_in;
  logic [N-1:0]       e_xd, e_yd, e_xa, e_ya;
  logic [N:0]         e_ra;
  logic [0:0]         e_mask;
  logic [0:0]         e_count;

  inside_multi #(.N(N), .K(K), .INCLUSIVE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .xD(xd), .yD(yd), .xA_bus(xa_bus), .yA_bus(ya_bus), .rA_bus(ra_bus),
    .out_valid(out_valid), .out_ready(out_ready),
    .mask(mask), .count(count), .all_in(all_in)
  );

  inside_multi #(.N(N), .K(1), .INCLUSIVE(0)) u_dut_ex (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .xD(e_xd), .yD(e_yd), .xA_bus(e_xa), .yA_bus(e_ya), .rA_bus(e_ra),
    .out_valid(e_out_valid), .out_ready(e_out_ready),
    .mask(e_mask), .count(e_count), .all_in(e_all_in)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer distance test against the radius
  function automatic bit ref_in(input int px, input int py, input int ax_, input int ay_,
                                input int r, input bit incl);
    longint dx, dy, d2, r2;
    dx = px - ax_;
    dy = py - ay_;
    d2 = dx*dx + dy*dy;
    r2 = longint'(r) * longint'(r);
    return incl ? (d2 <= r2) : (d2 < r2);
  endfunction

  int dxd, dyd;
  int ax[K], ay[K], ar[K];

  task automatic set_anchor(input int k, input int x_, input int y_, input int r_);
    ax[k] = x_; ay[k] = y_; ar[k] = r_;
  endtask

  // One request on the K=3 instance. noise: toggle inputs while busy.
  // hold: cycles to keep out_ready low after the result appears.
  task automatic run3(input string tag, input bit noise, input int hold);
    int n, em, ec;
    em = 0; ec = 0;
    for (int k = 0; k < K; k++) begin
      if (ref_in(dxd, dyd, ax[k], ay[k], ar[k], 1'b1)) begin
        em |= (1 << k);
        ec++;
      end
    end
    xd = dxd[N-1:0];
    yd = dyd[N-1:0];
    for (int k = 0; k < K; k++) begin
      xa_bus[k*N +: N]       = ax[k][N-1:0];
      ya_bus[k*N +: N]       = ay[k][N-1:0];
      ra_bus[k*(N+1) +: N+1] = ar[k][N:0];
    end
    chk({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        xd       = N'($urandom);
        xa_bus   = (K*N)'($urandom);
        ra_bus   = (K*(N+1))'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "/latency"}, n, 3*K);
    chk({tag, "/mask"},   {29'd0, mask},  em);
    chk({tag, "/count"},  {30'd0, count}, ec);
    chk({tag, "/all_in"}, {31'd0, all_in}, (em == 7) ? 1 : 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      xd       = N'($urandom);
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "/hold_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "/hold_mask"},  {29'd0, mask}, em);
      chk({tag, "/hold_count"}, {30'd0, count}, ec);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/drop_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "/back_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run1(input string tag, input int px, input int py, input int qx,
                      input int qy, input int r);
    int n, em;
    em = ref_in(px, py, qx, qy, r, 1'b0) ? 1 : 0;
    e_xd = px[N-1:0]; e_yd = py[N-1:0];
    e_xa = qx[N-1:0]; e_ya = qy[N-1:0]; e_ra = r[N:0];
    chk({tag, "/in_ready"}, {31'd0, e_in_ready}, 32'd1);
    e_in_valid = 1'b1;
    @(posedge clk); #1;
    e_in_valid = 1'b0;
    n = 0;
    while (!e_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/latency"}, n, 3);
    chk({tag, "/mask"},   {31'd0, e_mask},   em);
    chk({tag, "/count"},  {31'd0, e_count},  em);
    chk({tag, "/all_in"}, {31'd0, e_all_in}, em);
    e_out_ready = 1'b1;
    @(posedge clk); #1;
    e_out_ready = 1'b0;
    chk({tag, "/drop_valid"}, {31'd0, e_out_valid}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int seen;
    real rr;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    xd = '0; yd = '0; xa_bus = '0; ya_bus = '0; ra_bus = '0;
    e_in_valid = 1'b0; e_out_ready = 1'b0;
    e_xd = '0; e_yd = '0; e_xa = '0; e_ya = '0; e_ra = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst/in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst/out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst/mask",      {29'd0, mask},      32'd0);
    chk("rst/count",     {30'd0, count},     32'd0);
    chk("rst/all_in",    {31'd0, all_in},    32'd0);

    // Directed vectors
    dxd = 117; dyd = 83;
    set_anchor(0, -32, 108, 215);
    set_anchor(1, 109, -99, 183);
    set_anchor(2, -16, -111, 236);
    run3("vec1", 1'b1, 0);
    dxd = 180; dyd = 70;
    run3("vec2", 1'b0, 0);

    // Width extremes and the exact-boundary point
    dxd = 255; dyd = 255;
    for (int k = 0; k < K; k++) set_anchor(k, -128, -128, 511);
    run3("extreme_far", 1'b0, 0);
    dxd = 0; dyd = 0;
    for (int k = 0; k < K; k++) set_anchor(k, 0, 0, 0);
    run3("zero", 1'b0, 0);
    dxd = 3; dyd = 4;
    for (int k = 0; k < K; k++) set_anchor(k, 0, 0, 5);
    run3("edge_incl", 1'b0, 0);

    // Hold the result with out_ready low, then an immediate new request
    dxd = 117; dyd = 83;
    set_anchor(0, -32, 108, 215);
    set_anchor(1, 109, -99, 183);
    set_anchor(2, -16, -111, 236);
    run3("hold", 1'b1, 20);
    dxd = 180; dyd = 70;
    run3("after_hold", 1'b0, 0);

    // Reset during SQR of anchor 1
    dxd = 117; dyd = 83;
    xd = 8'd117; yd = 8'd83;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst/in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst/out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst/mask",      {29'd0, mask},      32'd0);
    chk("midrst/count",     {30'd0, count},     32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("midrst/no_result", seen, 0);
    run3("midrst/fresh", 1'b0, 0);

    // Random requests; radii sometimes chosen near the true distance
    for (int t = 0; t < 40; t++) begin
      dxd = $urandom_range(0, 255);
      dyd = $urandom_range(0, 255);
      for (int k = 0; k < K; k++) begin
        ax[k] = int'($urandom_range(0, 255)) - 128;
        ay[k] = int'($urandom_range(0, 255)) - 128;
        if ($urandom_range(0, 1) == 1) begin
          rr = $sqrt(real'((dxd-ax[k])*(dxd-ax[k]) + (dyd-ay[k])*(dyd-ay[k])));
          ar[k] = $rtoi(rr) + int'($urandom_range(0, 2)) - 1;
          if (ar[k] < 0) ar[k] = 0;
          if (ar[k] > 511) ar[k] = 511;
        end else begin
          ar[k] = $urandom_range(0, 511);
        end
      end
      run3($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 0);
    end

    // Exclusive K=1 instance
    run1("ex_edge",    3, 4, 0, 0, 5);
    run1("ex_zero",    0, 0, 0, 0, 0);
    run1("ex_vec",     117, 83, -32, 108, 215);
    run1("ex_extreme", 255, 255, -128, -128, 511);
    run1("ex_in",      10, 10, 0, 0, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
